// File: rtl/io_interface.sv
// Programmed-I/O bridge between the processor AC and one byte-wide device.
// RX and TX are independent circular FIFOs that produce the fgi/fgo skip flags.
module io_interface #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_inp,
  input  logic              f_out,
  input  logic [DATA_W-1:0] ac_lo,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              rx_underflow,
  output logic              tx_overflow
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];

  logic [RX_AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             rx_uf_q, rx_uf_d, tx_of_q, tx_of_d;
  logic             rx_push, rx_pop, tx_push, tx_pop;
  logic             rx_empty, rx_full, tx_empty, tx_full;

  // Next-state for both FIFOs; a rejected INP/OUT only touches its sticky flag.
  always_comb begin
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));

    rx_push = in_valid && !rx_full;
    rx_pop  = f_inp && !rx_empty;
    tx_push = f_out && !tx_full;
    tx_pop  = out_ready && !tx_empty;

    rx_rd_d  = rx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_cnt_d = rx_cnt_q;
    tx_rd_d  = tx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_cnt_d = tx_cnt_q;
    rx_uf_d  = rx_uf_q | (f_inp && rx_empty);
    tx_of_d  = tx_of_q | (f_out && tx_full);

    if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);
    if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + TX_AW'(1);

    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
      rx_uf_q  <= 1'b0;
      tx_of_q  <= 1'b0;
    end else begin
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_cnt_q <= rx_cnt_d;
      tx_rd_q  <= tx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_uf_q  <= rx_uf_d;
      tx_of_q  <= tx_of_d;
    end
  end

  // Storage is left uncleared by reset; writes are suppressed on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && rx_push) rx_mem_q[rx_wr_q] <= in_data;
    if (!reset && tx_push) tx_mem_q[tx_wr_q] <= ac_lo;
  end

  assign in_ready     = !rx_full;
  assign fgi          = !rx_empty;
  assign inpr         = rx_empty ? '0 : rx_mem_q[rx_rd_q];
  assign fgo          = !tx_full;
  assign out_valid    = !tx_empty;
  assign out_data     = tx_mem_q[tx_rd_q];
  assign rx_underflow = rx_uf_q;
  assign tx_overflow  = tx_of_q;

endmodule

// File: tb/tb_io_interface.sv
// Scoreboard bench for io_interface: stimulus queues expected bytes, a negedge
// monitor checks inpr on each accepted INP and out_data on each device pop.
module tb_io_interface;

  logic       clk = 1'b0;
  logic       reset, f_inp, f_out, in_valid, out_ready;
  logic [7:0] ac_lo, in_data;
  logic [7:0] inpr, out_data;
  logic       fgi, fgo, in_ready, out_valid, rx_underflow, tx_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  io_interface #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .f_inp(f_inp), .f_out(f_out), .ac_lo(ac_lo),
    .inpr(inpr), .fgi(fgi), .fgo(fgo), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .rx_underflow(rx_underflow), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes on the next rising edge, so check the data now.
  always @(negedge clk) begin
    if (!reset) begin
      if (f_inp && fgi) begin
        if (rx_exp.size() == 0) chk("rx_unexpected_pop", 32'(inpr), 32'hFFFF_FFFF);
        else chk("rx_inpr", 32'(inpr), 32'(rx_exp.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (tx_exp.size() == 0) chk("tx_unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
        else chk("tx_out_data", 32'(out_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; f_inp = 1'b0; f_out = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ac_lo = 8'h00; in_data = 8'h00;
    #1;
    step();
    chk("rst_fgi", 32'(fgi), 0);
    chk("rst_fgo", 32'(fgo), 1);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_inpr", 32'(inpr), 0);
    chk("rst_rx_uf", 32'(rx_underflow), 0);
    chk("rst_tx_of", 32'(tx_overflow), 0);
    reset = 1'b0;

    // RX order, then INP on an empty FIFO
    in_valid = 1'b1; in_data = 8'h11; rx_exp.push_back(8'h11);
    step();
    chk("rx_fgi_after_push", 32'(fgi), 1);
    in_data = 8'h22; rx_exp.push_back(8'h22); step();
    in_data = 8'h33; rx_exp.push_back(8'h33); step();
    in_valid = 1'b0;
    f_inp = 1'b1;
    repeat (3) step();
    f_inp = 1'b0;
    chk("rx_fgi_drained", 32'(fgi), 0);
    chk("rx_uf_before", 32'(rx_underflow), 0);
    f_inp = 1'b1; step(); f_inp = 1'b0;
    chk("rx_uf_set", 32'(rx_underflow), 1);
    chk("rx_fgi_after_uf", 32'(fgi), 0);
    chk("rx_inpr_empty", 32'(inpr), 0);

    // RX full: fifth byte held while INP pops the head
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h51 + i);
      rx_exp.push_back(in_data);
      step();
    end
    chk("rx_full_in_ready", 32'(in_ready), 0);
    in_data = 8'h55; rx_exp.push_back(8'h55);
    f_inp = 1'b1; step(); f_inp = 1'b0;
    chk("rx_held_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("rx_refull_in_ready", 32'(in_ready), 0);
    f_inp = 1'b1; repeat (4) step(); f_inp = 1'b0;
    chk("rx_full_drained", 32'(fgi), 0);

    // TX overflow under backpressure, then release
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f_out = 1'b1; ac_lo = 8'(8'hA0 + i);
      if (i < 4) tx_exp.push_back(ac_lo);
      step();
      if (i == 0) chk("tx_valid_after_out", 32'(out_valid), 1);
      if (i == 3) begin
        chk("tx_fgo_full", 32'(fgo), 0);
        chk("tx_of_not_yet", 32'(tx_overflow), 0);
      end
    end
    f_out = 1'b0;
    chk("tx_of_set", 32'(tx_overflow), 1);
    repeat (2) begin
      step();
      chk("tx_hold_data", 32'(out_data), 32'h A0);
      chk("tx_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    repeat (4) step();
    chk("tx_drained_valid", 32'(out_valid), 0);
    chk("tx_drained_fgo", 32'(fgo), 1);
    step();
    out_ready = 1'b0;

    // Simultaneous push and INP with pointer wrap
    in_valid = 1'b1;
    in_data = 8'h60; rx_exp.push_back(8'h60); step();
    in_data = 8'h61; rx_exp.push_back(8'h61); step();
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h62 + i); rx_exp.push_back(in_data);
      f_inp = 1'b1;
      step();
      chk("sim_fgi", 32'(fgi), 1);
      chk("sim_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    step();
    chk("sim_count_two", 32'(fgi), 1);
    step();
    f_inp = 1'b0;
    chk("sim_drained", 32'(fgi), 0);

    // Push and INP on an empty RX after a clean reset
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_rx_uf", 32'(rx_underflow), 0);
    in_valid = 1'b1; in_data = 8'h77; f_inp = 1'b1;
    step();
    in_valid = 1'b0; f_inp = 1'b0;
    chk("empty_sim_uf", 32'(rx_underflow), 1);
    chk("empty_sim_fgi", 32'(fgi), 1);
    chk("empty_sim_inpr", 32'(inpr), 32'h77);
    rx_exp.push_back(8'h77);
    f_inp = 1'b1; step(); f_inp = 1'b0;

    // Reset while both FIFOs hold data
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h81 + i);
      f_out = (i < 2); ac_lo = 8'(8'hB0 + i);
      step();
    end
    in_valid = 1'b0; f_out = 1'b0;
    chk("pre_rst_fgi", 32'(fgi), 1);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_fgi", 32'(fgi), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_fgo", 32'(fgo), 1);
    chk("mid_rst_inpr", 32'(inpr), 0);
    chk("mid_rst_rx_uf", 32'(rx_underflow), 0);
    in_valid = 1'b1; in_data = 8'h91; rx_exp.push_back(8'h91);
    f_out = 1'b1; ac_lo = 8'hC0; tx_exp.push_back(8'hC0);
    step();
    in_valid = 1'b0; f_out = 1'b0;
    chk("post_rst_inpr", 32'(inpr), 32'h91);
    chk("post_rst_out_data", 32'(out_data), 32'hC0);
    f_inp = 1'b1; out_ready = 1'b1;
    step();
    f_inp = 1'b0; out_ready = 1'b0;
    chk("post_rst_fgi", 32'(fgi), 0);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    step();
    chk("rx_queue_empty", 32'(rx_exp.size()), 0);
    chk("tx_queue_empty", 32'(tx_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_interface.md
# io_interface

Programmed-I/O block between the processor datapath/control unit and one external byte-wide device. It buffers device input in an RX FIFO and processor output in a TX FIFO. It executes the INP (F43) and OUT (F44) control pulses, and it produces the `fgi`/`fgo` status flags that the control unit samples for SFI/SFO skips.

## Interface
- `DATA_W`, 8: width of device bytes, INPR and OUTR; equals the low AC byte.
- `RX_DEPTH`, 4: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 4: TX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `f_inp`  in  1  control word F43 (INP); one-cycle pulse.
- `f_out`  in  1  control word F44 (OUT); one-cycle pulse.
- `ac_lo`  in  DATA_W  AC[DATA_W-1:0], sampled when `f_out`=1.
- `inpr`  out  DATA_W  RX FIFO head; the AC loads it on the `f_inp` edge.
- `fgi`  out  1  input flag: RX FIFO non-empty.
- `fgo`  out  1  output flag: TX FIFO not full.
- `in_valid`  in  1  device offers `in_data`.
- `in_data`  in  DATA_W  device input byte.
- `in_ready`  out  1  RX FIFO can accept a byte.
- `out_valid`  out  1  TX FIFO head is valid.
- `out_data`  out  DATA_W  TX FIFO head.
- `out_ready`  in  1  device accepts `out_data`.
- `rx_underflow`  out  1  sticky: INP issued while RX was empty.
- `tx_overflow`  out  1  sticky: OUT issued while TX was full.

## Operation
**FIFO storage**
- Each FIFO is a circular buffer with its own storage, read pointer, write pointer and occupancy count.
- Pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits and range 0..DEPTH.

**RX FIFO**
- Push when `in_valid && in_ready`.
- Pop when `f_inp && count_rx != 0`.
- `in_ready` = (count_rx < RX_DEPTH).
- `fgi` = (count_rx != 0).
- `inpr` = storage[rd_ptr] when non-empty, else 0.

**TX FIFO**
- Push `ac_lo` when `f_out && count_tx != TX_DEPTH`.
- Pop when `out_valid && out_ready`.
- `out_valid` = (count_tx != 0).
- `out_data` = storage[rd_ptr].
- `fgo` = (count_tx != TX_DEPTH).

**Simultaneous events**
- Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- RX full with `f_inp` in the same cycle: `in_ready` is already 0, so no push. The pop proceeds.
- RX empty with push and `f_inp` in the same cycle: the byte is stored, the pop is ignored, and `rx_underflow` sets. No bypass path.
- TX full with `f_out` and a device pop in the same cycle: the push is rejected and `tx_overflow` sets. The pop proceeds.

**Errors**
- A rejected INP or OUT leaves FIFO state unchanged.
- `rx_underflow` and `tx_overflow` stay set until `reset`.
- Both FIFOs tolerate `f_inp` and `f_out` asserted in the same cycle; they are independent.

## Timing
**Reset values** (applied on the first rising edge with `reset`=1):
- Counts and pointers = 0.
- Sticky error flags = 0.
- Therefore `fgi`=0, `fgo`=1, `in_ready`=1, `out_valid`=0, `inpr`=0, `out_data`=don't-care (bench ignores it while `out_valid`=0).
- Storage contents are not cleared.
- A reset asserted mid-transfer discards all buffered bytes; no handshake completes on the reset edge.

**Latencies**
- Device push → `fgi`=1: one cycle (visible after the accepting edge).
- INP: the AC captures `inpr` on the same edge that pops the head. The new head or `fgi`=0 is visible after that edge.
- OUT: `ac_lo` is captured on the `f_out` edge. `out_valid`=1 the next cycle when TX was empty. `fgo` updates after the same edge.
- Flag outputs are pure functions of registered counts, so there are no combinational paths from `f_inp`/`f_out` to any output.
- `out_data` and `out_valid` hold stable while `out_valid && !out_ready`.
- Sustained throughput: one byte per cycle per direction.

## Test plan
- **Reset:** assert `reset` 1 cycle → `fgi`=0, `fgo`=1, `in_ready`=1, `out_valid`=0, `inpr`=0, both error flags 0.
- **RX order and fill:**
  - Device pushes 0x11, 0x22, 0x33 → `fgi`=1 one cycle after the first push.
  - Three `f_inp` pulses → `inpr` reads 0x11, 0x22, 0x33 in order; `fgi`=0 after the third.
  - A fourth `f_inp` → `rx_underflow`=1, pointers unchanged.
- **RX full:** device pushes 5 bytes back-to-back with RX_DEPTH=4 → `in_ready`=0 after the 4th; the 5th is held by the device.
  - `f_inp` in the same cycle as the held 5th byte → pop 1st byte, no push.
  - Next cycle the 5th byte is accepted.
- **TX overflow and backpressure:** `out_ready`=0, five `f_out` pulses with `ac_lo`=0xA0..0xA4 → `fgo`=0 after the 4th, `tx_overflow`=1 on the 5th.
  - `out_data` holds 0xA0 stably.
  - Release `out_ready` → 0xA0..0xA3 emitted on consecutive cycles; 0xA4 never appears.
- **Simultaneous events and wrap-around:** RX holds 2 bytes; drive a device push and `f_inp` in the same cycle → count stays 2, order preserved.
  - Repeat for 10 cycles so the pointers wrap → stream is intact.
  - RX empty with push + `f_inp` in the same cycle → byte retained, `rx_underflow`=1.
- **Reset mid-operation:** RX has 3 bytes and TX has 2 bytes with `out_ready`=0; assert `reset` → next cycle `fgi`=0, `out_valid`=0, `fgo`=1.
  - Subsequent pushes start at entry 0.
